pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control back-end that consumes the 10-bit control rod produced by the decoder. It carries each decoded instruction's rod and register indices through the EX, MEM and WB stage registers. It also detects load-use hazards (stall plus bubble), resolves branch/jump squashes, generates EX-stage operand forwarding selects, and counts retired instructions. It sits between decode and the datapath stage registers.

## Interface
- `REG_AW`, default 4: register index width.
- `CNT_W`, default 32: retired-instruction counter width.
- `clk` in 1: clock, rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rod` in 10: control rod of the ID instruction. Bits: [2:0] ALU op, 3 IsBranch, 4 IsLoad, 5 IsMemWrite, 6 IsRegWrite, 7 JMP, 8 reads rs2, 9 reads rs1.
- `id_rs1`, `id_rs2`, `id_rd` in REG_AW each: ID register indices.
- `ex_eq` in 1: EX comparator result for BEQ.
- `stall` out 1: hold PC and IF/ID this cycle.
- `flush` out 1: clear IF/ID and redirect the PC this cycle.
- `ex_rod`, `mem_rod`, `wb_rod` out 10 each: stage control rods; 0 when the stage holds a bubble.
- `mem_rd`, `wb_rd` out REG_AW each: destination indices.
- `fwd_a`, `fwd_b` out 2 each: EX operand select. 00 = regfile, 01 = MEM result, 10 = WB result.
- `retired` out CNT_W: count of instructions leaving WB.

## Operation
- Stage registers: EX, MEM and WB each hold {valid, rod, rs1, rs2, rd}. They advance every clock; there is no external back-pressure.
- EX load rule: EX loads from ID unless a bubble is injected. A bubble is valid=0 with rod, rs1, rs2 and rd all 0.
- Bubble injected into EX when any of the following holds:
  - `id_valid` is 0.
  - `stall` is 1.
  - `flush` is 1.
- Load-use hazard: `stall` = ID valid AND EX valid AND `ex_rod[4]` AND any of:
  - `id_rod[9]` and `id_rs1 == ex_rd`.
  - `id_rod[8]` and `id_rs2 == ex_rd`.
- Taken control transfer: `flush` = EX valid AND (`ex_rod[7]` OR (`ex_rod[3]` AND `ex_eq`)).
  - The younger instruction in ID is squashed (bubble into EX).
  - The IF/ID clear is the fetch side's responsibility, triggered by `flush`.
- Stall/flush exclusivity: the two are mutually exclusive by construction, because a rod never sets both bit 4 and bit 3/7. If both are ever asserted, flush wins and stall is forced to 0.
- Forwarding for EX operand A (B is identical, using rs2):
  - Select 01 if MEM valid, `mem_rod[6]`, NOT `mem_rod[4]`, and `mem_rd == ex_rs1`.
  - Otherwise select 10 if WB valid, `wb_rod[6]` and `wb_rd == ex_rs1`.
  - Otherwise select 00.
  - MEM has priority over WB.
  - Forward selects are 00 whenever EX holds a bubble.
- NOP (rod 0, valid) flows as a normal instruction: no hazards, no forwarding, and it is counted at retire.
- `retired` increments when WB valid is 1 at a clock edge. It wraps modulo 2^CNT_W.

## Timing
- `stall`, `flush`, `fwd_a` and `fwd_b` are combinational from the current stage registers and ID inputs, valid in the same cycle.
- A load-use stall lasts exactly 1 cycle. The next cycle the load is in MEM and EX holds a bubble, so `stall` drops. The consumer then reaches EX with the load in WB and takes `fwd` = 10.
- Flush penalty: 1 cycle, the squashed ID slot becomes an EX bubble.
- Reset, asynchronous and immediate: all valid bits, rods, indices and `retired` go to 0, so `stall`, `flush` and `fwd` read 0 during and after reset.
- Reset may assert mid-pipeline; every in-flight instruction is discarded and nothing is counted.

## Structure
- Shared package `pipe_pkg`:
  - Rod bit-index constants: ROD_BR=3, ROD_LD=4, ROD_MW=5, ROD_RW=6, ROD_JMP=7, ROD_RD2=8, ROD_RD1=9.
  - Forward encodings: FWD_RF, FWD_MEM, FWD_WB.
  - Stage-record typedef.
- One sub-module `pipe_stage_reg`: the per-stage record register with async reset and a bubble-insert input. It is instantiated three times.

## Test plan
- Reset mid-run with 3 valid instructions in flight → all rods 0, `retired`=0, `stall`/`flush`=0 immediately. After release, the first ADD (rod 0x341) retires 3 cycles after entering EX.
- LD r2 (0x050) followed by ADD r3=r2+r1 (0x341, rs1=2) → `stall`=1 for exactly one cycle, EX bubble, then ADD in EX with `fwd_a`=10.
- ADD r4 then INC r5=r4 (0x243, rs1=4), back-to-back → no stall, `fwd_a`=01. The same INC with one NOP between → `fwd_a`=10.
- BEQ (0x008) in EX with `ex_eq`=1 → `flush`=1 that cycle, next EX is a bubble. With `ex_eq`=0 → no flush. JMP (0x080) → `flush`=1 regardless of `ex_eq`.
- Both MEM and WB write r6, EX reads r6 on both operands → `fwd_a`=`fwd_b`=01. MEM is a load of r6 instead → 10.
- Force `retired` to all-ones (CNT_W=4 build, 15 retires), retire one more → wraps to 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline control back-end.
//   - Bit positions inside the 10-bit control rod produced by decode.
//   - Operand-forwarding select encodings used by the EX stage muxes.
//   - The control half of a stage record. Register indices are kept
//     separate because their width is a per-instance parameter.
package pipe_pkg;

  localparam int ROD_W   = 10;
  localparam int ROD_BR  = 3;
  localparam int ROD_LD  = 4;
  localparam int ROD_MW  = 5;
  localparam int ROD_RW  = 6;
  localparam int ROD_JMP = 7;
  localparam int ROD_RD2 = 8;
  localparam int ROD_RD1 = 9;

  typedef logic [ROD_W-1:0] rod_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_e;

  typedef struct packed {
    logic vld;
    rod_t rod;
  } stage_ctl_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline stage record {valid, rod, rs1, rs2, rd}.
// Ports:
//   clk, rst      - rising-edge clock, asynchronous active-high reset
//   bubble        - load an all-zero record instead of the input
//   d_ctl, d_rs*  - incoming record (valid + rod, register indices)
//   q_ctl, q_rs*  - registered record
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bubble,
  input  stage_ctl_t        d_ctl,
  input  logic [REG_AW-1:0] d_rs1,
  input  logic [REG_AW-1:0] d_rs2,
  input  logic [REG_AW-1:0] d_rd,
  output stage_ctl_t        q_ctl,
  output logic [REG_AW-1:0] q_rs1,
  output logic [REG_AW-1:0] q_rs2,
  output logic [REG_AW-1:0] q_rd
);

  // A bubble clears every field, not just valid, so downstream rods
  // and indices read as zero for an empty slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || bubble) begin
      q_ctl <= '0;
      q_rs1 <= '0;
      q_rs2 <= '0;
      q_rd  <= '0;
    end else begin
      q_ctl <= d_ctl;
      q_rs1 <= d_rs1;
      q_rs2 <= d_rs2;
      q_rd  <= d_rd;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control back-end behind decode.
// Carries each instruction's rod and register indices through EX, MEM
// and WB, detects load-use hazards, resolves branch/jump squashes,
// produces EX operand forwarding selects and counts retirements.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   id_valid, id_rod          - ID instruction present / its control rod
//   id_rs1, id_rs2, id_rd     - ID register indices
//   ex_eq                     - EX comparator result for BEQ
//   stall, flush              - hazard stall / taken-transfer squash
//   ex_rod, mem_rod, wb_rod   - stage rods (0 for a bubble)
//   mem_rd, wb_rd             - destination indices in MEM and WB
//   fwd_a, fwd_b              - EX operand selects (00 RF, 01 MEM, 10 WB)
//   retired                   - instructions retired, wraps
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [9:0]        id_rod,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_eq,
  output logic              stall,
  output logic              flush,
  output logic [9:0]        ex_rod,
  output logic [9:0]        mem_rod,
  output logic [9:0]        wb_rod,
  output logic [REG_AW-1:0] mem_rd,
  output logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  retired
);

  stage_ctl_t        id_ctl, ex_ctl_p0, mem_ctl_p1, wb_ctl_p2;
  logic [REG_AW-1:0] ex_rs1_p0, ex_rs2_p0, ex_rd_p0;
  logic [REG_AW-1:0] mem_rs1_p1, mem_rs2_p1, mem_rd_p1;
  logic [REG_AW-1:0] wb_rs1_p2, wb_rs2_p2, wb_rd_p2;
  logic              vld_p0, vld_p1, vld_p2;
  logic              ex_bubble, stall_raw;
  logic [CNT_W-1:0]  retired_q;
  logic              unused_idx;

  assign id_ctl = '{vld: id_valid, rod: id_rod};

  assign vld_p0 = ex_ctl_p0.vld;
  assign vld_p1 = mem_ctl_p1.vld;
  assign vld_p2 = wb_ctl_p2.vld;

  // Source indices are only consulted in EX; later stages keep them
  // so the record shape is uniform.
  assign unused_idx = ^{mem_rs1_p1, mem_rs2_p1, wb_rs1_p2, wb_rs2_p2};

  // Pick the youngest older producer of src. A load in MEM has no data
  // yet, so it is skipped; the load-use stall guarantees the consumer
  // only meets it again once it sits in WB.
  function automatic fwd_e fwd_sel(input logic [REG_AW-1:0] src);
    fwd_e sel;
    sel = FWD_RF;
    if (vld_p0) begin
      if (vld_p1 && mem_ctl_p1.rod[ROD_RW] && !mem_ctl_p1.rod[ROD_LD] &&
          (mem_rd_p1 == src))
        sel = FWD_MEM;
      else if (vld_p2 && wb_ctl_p2.rod[ROD_RW] && (wb_rd_p2 == src))
        sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    flush = vld_p0 &&
            (ex_ctl_p0.rod[ROD_JMP] || (ex_ctl_p0.rod[ROD_BR] && ex_eq));
    stall_raw = id_valid && vld_p0 && ex_ctl_p0.rod[ROD_LD] &&
                ((id_rod[ROD_RD1] && (id_rs1 == ex_rd_p0)) ||
                 (id_rod[ROD_RD2] && (id_rs2 == ex_rd_p0)));
    // Cannot coincide for decoder-legal rods; if it ever does, the
    // squash makes the stalled instruction irrelevant.
    stall     = stall_raw && !flush;
    ex_bubble = !id_valid || stall || flush;
    fwd_a     = fwd_sel(ex_rs1_p0);
    fwd_b     = fwd_sel(ex_rs2_p0);
  end

  // ID -> EX
  pipe_stage_reg #(.REG_AW(REG_AW)) u_ex (
    .clk(clk), .rst(rst), .bubble(ex_bubble),
    .d_ctl(id_ctl), .d_rs1(id_rs1), .d_rs2(id_rs2), .d_rd(id_rd),
    .q_ctl(ex_ctl_p0), .q_rs1(ex_rs1_p0), .q_rs2(ex_rs2_p0), .q_rd(ex_rd_p0)
  );

  // EX -> MEM
  pipe_stage_reg #(.REG_AW(REG_AW)) u_mem (
    .clk(clk), .rst(rst), .bubble(1'b0),
    .d_ctl(ex_ctl_p0), .d_rs1(ex_rs1_p0), .d_rs2(ex_rs2_p0), .d_rd(ex_rd_p0),
    .q_ctl(mem_ctl_p1), .q_rs1(mem_rs1_p1), .q_rs2(mem_rs2_p1), .q_rd(mem_rd_p1)
  );

  // MEM -> WB
  pipe_stage_reg #(.REG_AW(REG_AW)) u_wb (
    .clk(clk), .rst(rst), .bubble(1'b0),
    .d_ctl(mem_ctl_p1), .d_rs1(mem_rs1_p1), .d_rs2(mem_rs2_p1), .d_rd(mem_rd_p1),
    .q_ctl(wb_ctl_p2), .q_rs1(wb_rs1_p2), .q_rs2(wb_rs2_p2), .q_rd(wb_rd_p2)
  );

  // WB -> retire
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      retired_q <= '0;
    else if (vld_p2)
      retired_q <= retired_q + 1'b1;
  end

  assign ex_rod  = ex_ctl_p0.rod;
  assign mem_rod = mem_ctl_p1.rod;
  assign wb_rod  = wb_ctl_p2.rod;
  assign mem_rd  = mem_rd_p1;
  assign wb_rd   = wb_rd_p2;
  assign retired = retired_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl (CNT_W=4 build so the
// retire counter wraps). A driver issues one ID slot per cycle, predicts
// the cycle's outputs from a slot-level model of the pipeline and queues
// them; a monitor pops and compares on every falling edge.
module tb_pipe_ctrl;

  localparam int REG_AW = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [9:0]        id_rod;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              ex_eq;
  logic              stall, flush;
  logic [9:0]        ex_rod, mem_rod, wb_rod;
  logic [REG_AW-1:0] mem_rd, wb_rd;
  logic [1:0]        fwd_a, fwd_b;
  logic [CNT_W-1:0]  retired;

  always #5 clk = ~clk;

  pipe_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rod(id_rod),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_eq(ex_eq),
    .stall(stall), .flush(flush), .ex_rod(ex_rod), .mem_rod(mem_rod),
    .wb_rod(wb_rod), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .retired(retired)
  );

  typedef struct {
    bit       v;
    bit [9:0] rod;
    bit [3:0] rs1, rs2, rd;
  } ins_t;

  typedef struct {
    bit       stall, flush;
    bit [1:0] fa, fb;
    bit [9:0] exr, memr, wbr;
    bit [3:0] memrd, wbrd;
    bit [3:0] ret;
  } exp_t;

  exp_t        sbq[$];
  ins_t        ex_m, mem_m, wb_m;
  ins_t        empty_slot;
  int unsigned cnt_m;
  int          checks = 0;
  int          errors = 0;

  bit [9:0] rod_tab [7] = '{10'h341, 10'h243, 10'h050, 10'h008,
                            10'h080, 10'h000, 10'h320};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: source of an EX operand is the youngest older writer
  // whose value exists (a load only has data once it reaches WB).
  function automatic bit [1:0] ref_fwd(input bit [3:0] src);
    if (!ex_m.v) return 2'b00;
    if (mem_m.v && mem_m.rod[6] && !mem_m.rod[4] && mem_m.rd == src) return 2'b01;
    if (wb_m.v && wb_m.rod[6] && wb_m.rd == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit reads(input bit [9:0] rod, input bit [3:0] s1,
                               input bit [3:0] s2, input bit [3:0] r);
    return (rod[9] && s1 == r) || (rod[8] && s2 == r);
  endfunction

  // One clock: present ID, queue this cycle's expectation, advance model.
  task automatic step(input bit v, input bit [9:0] rod, input bit [3:0] s1,
                      input bit [3:0] s2, input bit [3:0] d, input bit eq,
                      output bit stalled);
    exp_t e;
    bit   fl, st;
    id_valid = v; id_rod = rod; id_rs1 = s1; id_rs2 = s2; id_rd = d; ex_eq = eq;
    fl = ex_m.v && (ex_m.rod[7] || (ex_m.rod[3] && eq));
    st = !fl && v && ex_m.v && ex_m.rod[4] && reads(rod, s1, s2, ex_m.rd);
    e.stall = st;          e.flush = fl;
    e.fa    = ref_fwd(ex_m.rs1);
    e.fb    = ref_fwd(ex_m.rs2);
    e.exr   = ex_m.rod;    e.memr  = mem_m.rod;  e.wbr = wb_m.rod;
    e.memrd = mem_m.rd;    e.wbrd  = wb_m.rd;
    e.ret   = cnt_m[3:0];
    sbq.push_back(e);
    @(posedge clk);
    if (!rst) begin
      if (wb_m.v) cnt_m = (cnt_m + 1) % 16;
      wb_m  = mem_m;
      mem_m = ex_m;
      if (!v || st || fl) ex_m = empty_slot;
      else                ex_m = '{1'b1, rod, s1, s2, d};
    end
    #1;
    stalled = st;
  endtask

  // Present an instruction until the pipeline accepts it.
  task automatic issue(input bit [9:0] rod, input bit [3:0] s1, input bit [3:0] s2,
                       input bit [3:0] d, input bit eq);
    bit st;
    int n = 0;
    do begin
      step(1'b1, rod, s1, s2, d, eq, st);
      n++;
    end while (st && n < 4);
  endtask

  task automatic nops(input int n);
    bit st;
    for (int i = 0; i < n; i++) step(1'b1, 10'h000, 4'd0, 4'd0, 4'd0, 1'b0, st);
  endtask

  task automatic reset_mid();
    bit st;
    rst = 1'b1;
    ex_m = empty_slot; mem_m = empty_slot; wb_m = empty_slot; cnt_m = 0;
    for (int i = 0; i < 2; i++)
      step(1'b1, 10'h341, 4'($urandom_range(0, 7)), 4'd1, 4'd2, 1'b1, st);
    rst = 1'b0;
  endtask

  // Monitor: compare whatever the DUT presents against the next expectation.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("stall",   int'(stall),   int'(e.stall));
      chk("flush",   int'(flush),   int'(e.flush));
      chk("fwd_a",   int'(fwd_a),   int'(e.fa));
      chk("fwd_b",   int'(fwd_b),   int'(e.fb));
      chk("ex_rod",  int'(ex_rod),  int'(e.exr));
      chk("mem_rod", int'(mem_rod), int'(e.memr));
      chk("wb_rod",  int'(wb_rod),  int'(e.wbr));
      chk("mem_rd",  int'(mem_rd),  int'(e.memrd));
      chk("wb_rd",   int'(wb_rd),   int'(e.wbrd));
      chk("retired", int'(retired), int'(e.ret));
    end
  end

  initial begin
    bit st;
    int k;
    empty_slot = '{1'b0, 10'h000, 4'd0, 4'd0, 4'd0};
    ex_m = empty_slot; mem_m = empty_slot; wb_m = empty_slot; cnt_m = 0;
    rst = 1'b1;
    id_valid = 1'b0; id_rod = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; ex_eq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(1'b1, 10'h341, 4'd1, 4'd2, 4'd3, 1'b0, st);  // held in reset
    rst = 1'b0;

    // three in flight, then reset mid-pipeline; afterwards one ADD retires
    issue(10'h341, 4'd1, 4'd2, 4'd3, 1'b0);
    issue(10'h243, 4'd3, 4'd0, 4'd4, 1'b0);
    issue(10'h341, 4'd4, 4'd3, 4'd5, 1'b0);
    reset_mid();
    issue(10'h341, 4'd1, 4'd2, 4'd3, 1'b0);
    step(1'b0, 10'h000, 4'd0, 4'd0, 4'd0, 1'b0, st);
    step(1'b0, 10'h000, 4'd0, 4'd0, 4'd0, 1'b0, st);
    step(1'b0, 10'h000, 4'd0, 4'd0, 4'd0, 1'b0, st);
    step(1'b0, 10'h000, 4'd0, 4'd0, 4'd0, 1'b0, st);

    // load-use: one-cycle stall then WB forward
    issue(10'h050, 4'd0, 4'd0, 4'd2, 1'b0);
    issue(10'h341, 4'd2, 4'd1, 4'd3, 1'b0);
    nops(3);

    // back-to-back ALU forward from MEM, then from WB with a NOP between
    issue(10'h341, 4'd1, 4'd2, 4'd4, 1'b0);
    issue(10'h243, 4'd4, 4'd0, 4'd5, 1'b0);
    nops(2);
    issue(10'h341, 4'd1, 4'd2, 4'd4, 1'b0);
    nops(1);
    issue(10'h243, 4'd4, 4'd0, 4'd5, 1'b0);
    nops(3);

    // BEQ taken, BEQ not taken, JMP with eq low
    issue(10'h008, 4'd0, 4'd0, 4'd0, 1'b0);
    issue(10'h341, 4'd1, 4'd1, 4'd1, 1'b1);
    issue(10'h008, 4'd0, 4'd0, 4'd0, 1'b0);
    issue(10'h341, 4'd1, 4'd1, 4'd1, 1'b0);
    issue(10'h080, 4'd0, 4'd0, 4'd0, 1'b0);
    issue(10'h341, 4'd1, 4'd1, 4'd1, 1'b0);
    nops(3);

    // MEM vs WB priority on r6, then with a load of r6 in the middle
    issue(10'h341, 4'd1, 4'd2, 4'd6, 1'b0);
    issue(10'h341, 4'd1, 4'd2, 4'd6, 1'b0);
    issue(10'h341, 4'd6, 4'd6, 4'd7, 1'b0);
    nops(3);
    issue(10'h341, 4'd1, 4'd2, 4'd6, 1'b0);
    issue(10'h050, 4'd0, 4'd0, 4'd6, 1'b0);
    issue(10'h341, 4'd6, 4'd6, 4'd7, 1'b0);
    nops(3);

    // retire counter wrap
    reset_mid();
    nops(22);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      bit [9:0] rod;
      if ($urandom_range(0, 150) == 0) begin
        reset_mid();
      end else begin
        k = $urandom_range(0, 7);
        if (k == 7) rod = 10'($urandom);
        else        rod = rod_tab[k];
        if ($urandom_range(0, 9) == 0)
          step(1'b0, rod, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
               4'($urandom_range(0, 7)), 1'($urandom), st);
        else
          issue(rod, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                4'($urandom_range(0, 7)), 1'($urandom));
      end
    end
    for (int i = 0; i < 4; i++) step(1'b0, 10'h000, 4'd0, 4'd0, 4'd0, 1'b0, st);

    k = 0;
    while (sbq.size() > 0 && k < 10) begin
      @(posedge clk);
      k++;
    end
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
